// File: rtl/syrup_offchip_arbiter_n.sv
`default_nettype none
// syrup_offchip_arbiter_n: N-channel off-chip memory arbiter; round-robin or fixed priority
// with starvation promotion. Rev 1.0
module syrup_offchip_arbiter_n #(
   parameter int NUM_PORTS    = 4,
   parameter int W_OFF_A      = 32,
   parameter int W_OFF_D      = 512,
   parameter int MODE         = 0,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic [NUM_PORTS*W_OFF_A-1:0]   ADDR,
   input  logic [NUM_PORTS-1:0]           RE,
   input  logic [NUM_PORTS-1:0]           WE,
   input  logic [NUM_PORTS*W_OFF_D-1:0]   D,
   output logic [NUM_PORTS*W_OFF_D-1:0]   Q,
   output logic [NUM_PORTS-1:0]           RDY,
   output logic [W_OFF_A-1:0]             MEM_ADDR,
   output logic                           MEM_RE,
   output logic                           MEM_WE,
   output logic [W_OFF_D-1:0]             MEM_D,
   input  logic [W_OFF_D-1:0]             MEM_Q,
   input  logic                           MEM_RDY,
   output logic                           BUSY,
   output logic [2:0]                     GRANT_ID
);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

   state_t               state;
   logic [NUM_PORTS-1:0] req;
   logic [PW-1:0]        rr_ptr;
   logic [7:0]           starve_cnt [NUM_PORTS];
   logic                 op_we;

   logic [2:0]           winner;
   logic [2:0]           prom_winner;
   logic                 found;
   logic                 any_prom;
   logic [PW:0]          rr_idx;
   logic [W_OFF_A-1:0]   sel_addr;
   logic [W_OFF_D-1:0]   sel_d;
   logic                 sel_we;

   assign req = RE | WE;

   always_comb begin
      winner      = '0;
      prom_winner = '0;
      found       = 1'b0;
      any_prom    = 1'b0;
      rr_idx      = '0;
      if (MODE == 0) begin
         // Scan starts one past the last grant, so the previous winner is visited last.
         for (int k = 1; k <= NUM_PORTS; k++) begin
            rr_idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (rr_idx >= (PW+1)'(NUM_PORTS))
               rr_idx = rr_idx - (PW+1)'(NUM_PORTS);
            if (!found && req[rr_idx[PW-1:0]]) begin
               winner = 3'(rr_idx[PW-1:0]);
               found  = 1'b1;
            end
         end
      end else begin
         for (int i = NUM_PORTS-1; i >= 0; i--) begin
            if (req[i])
               winner = 3'(i);
            if (STARVE_LIMIT > 0 && req[i] && starve_cnt[i] >= 8'(STARVE_LIMIT)) begin
               prom_winner = 3'(i);
               any_prom    = 1'b1;
            end
         end
         if (any_prom)
            winner = prom_winner;
      end

      sel_addr = '0;
      sel_d    = '0;
      sel_we   = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (winner == 3'(i)) begin
            sel_addr = ADDR[i*W_OFF_A +: W_OFF_A];
            sel_d    = D[i*W_OFF_D +: W_OFF_D];
            sel_we   = WE[i];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= S_IDLE;
         Q        <= '0;
         RDY      <= '0;
         MEM_ADDR <= '0;
         MEM_RE   <= 1'b0;
         MEM_WE   <= 1'b0;
         MEM_D    <= '0;
         BUSY     <= 1'b0;
         GRANT_ID <= '0;
         op_we    <= 1'b0;
         rr_ptr   <= PW'(NUM_PORTS-1);
         for (int i = 0; i < NUM_PORTS; i++)
            starve_cnt[i] <= '0;
      end else begin
         RDY    <= '0;
         MEM_RE <= 1'b0;
         MEM_WE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  GRANT_ID <= winner;
                  MEM_ADDR <= sel_addr;
                  MEM_D    <= sel_d;
                  op_we    <= sel_we;
                  MEM_WE   <= sel_we;
                  MEM_RE   <= !sel_we;
                  BUSY     <= 1'b1;
                  rr_ptr   <= winner[PW-1:0];
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               if (MEM_RDY) begin
                  for (int i = 0; i < NUM_PORTS; i++) begin
                     if (GRANT_ID == 3'(i)) begin
                        RDY[i] <= 1'b1;
                        if (!op_we)
                           Q[i*W_OFF_D +: W_OFF_D] <= MEM_Q;
                     end
                  end
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               BUSY  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // Any request present in IDLE means this is a grant cycle.
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (!req[i])
               starve_cnt[i] <= '0;
            else if (state == S_IDLE) begin
               if (winner == 3'(i))
                  starve_cnt[i] <= '0;
               else if (starve_cnt[i] != 8'hFF)
                  starve_cnt[i] <= starve_cnt[i] + 8'd1;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_syrup_offchip_arbiter_n.sv
`default_nettype none
// tb_syrup_offchip_arbiter_n: scoreboard bench; instance 0 runs round-robin, instance 1 fixed
// priority with STARVE_LIMIT=2, each against a transaction-level arbitration model.
module tb_syrup_offchip_arbiter_n;
   localparam int NP  = 4;
   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int LIM = 2;

   typedef struct {
      int             port;
      bit             we;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  data;
      logic [DW-1:0]  rdata;
   } exp_t;

   typedef struct {
      bit             re;
      bit             we;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  data;
   } txn_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [NP-1:0]    re_s [2];
   logic [NP-1:0]    we_s [2];
   logic [NP*AW-1:0] addr_s [2];
   logic [NP*DW-1:0] d_s [2];
   logic [NP*DW-1:0] q_o [2];
   logic [NP-1:0]    rdy_o [2];
   logic [AW-1:0]    mem_addr_o [2];
   logic             mem_re_o [2];
   logic             mem_we_o [2];
   logic [DW-1:0]    mem_d_o [2];
   logic [DW-1:0]    mem_q_s [2];
   logic             mem_rdy_s [2];
   logic             busy_o [2];
   logic [2:0]       gid_o [2];

   int n_chk  = 0;
   int n_fail = 0;

   exp_t          sb_q [2][$];
   int            glog [2][$];
   txn_t          pq [NP][$];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   logic [DW-1:0] ext_mem [logic [AW-1:0]];
   logic [DW-1:0] q_model [2][NP];
   int            rr_ptr_m [2];
   int            rsp_delay [2];
   bit            spur_issue [2];
   bit            hang [2];
   bit            chk_gap [2];
   bit            have_prev [2];
   bit            strobe_seen [2];
   int            rsp_cyc [2];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected event at t=%0t", name, $time);
   endtask

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return {~a, a};
   endfunction

   function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   function automatic logic [DW-1:0] rd_ext(input logic [AW-1:0] a);
      return ext_mem.exists(a) ? ext_mem[a] : init_val(a);
   endfunction

   function automatic logic [NP*DW-1:0] qpack(input int k);
      logic [NP*DW-1:0] r;
      r = '0;
      for (int p = 0; p < NP; p++) r[p*DW +: DW] = q_model[k][p];
      return r;
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_dut
      syrup_offchip_arbiter_n #(
         .NUM_PORTS(NP), .W_OFF_A(AW), .W_OFF_D(DW),
         .MODE(k), .STARVE_LIMIT(k == 1 ? LIM : 8)
      ) dut (
         .CLK(clk), .RST(rst_n), .ADDR(addr_s[k]), .RE(re_s[k]), .WE(we_s[k]), .D(d_s[k]),
         .Q(q_o[k]), .RDY(rdy_o[k]), .MEM_ADDR(mem_addr_o[k]), .MEM_RE(mem_re_o[k]),
         .MEM_WE(mem_we_o[k]), .MEM_D(mem_d_o[k]), .MEM_Q(mem_q_s[k]), .MEM_RDY(mem_rdy_s[k]),
         .BUSY(busy_o[k]), .GRANT_ID(gid_o[k])
      );

      // Monitor: checks every strobe against the scoreboard head, pops on RDY.
      initial begin : mon
         bit   prev_s, after_rdy, s;
         int   last_rdy;
         exp_t e;
         prev_s = 0; after_rdy = 0; last_rdy = 0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               prev_s = 0; after_rdy = 0;
            end else begin
               s = mem_re_o[k] || mem_we_o[k];
               if (after_rdy) chk("busy_fall", busy_o[k], 0);
               after_rdy = 0;
               if (s) begin
                  chk("strobe_width", prev_s, 0);
                  strobe_seen[k] = 1;
                  glog[k].push_back(int'(gid_o[k]));
                  if (sb_q[k].size() == 0) fail_now("unexpected_strobe");
                  else begin
                     e = sb_q[k][0];
                     chk("grant_id", gid_o[k], e.port);
                     chk("mem_we", mem_we_o[k], e.we);
                     chk("mem_re", mem_re_o[k], !e.we);
                     chk("mem_addr", mem_addr_o[k], e.addr);
                     if (e.we) chk("mem_d", mem_d_o[k], e.data);
                     chk("busy_issue", busy_o[k], 1);
                  end
               end
               prev_s = s;
               if (rdy_o[k] != '0) begin
                  if (sb_q[k].size() == 0) fail_now("unexpected_rdy");
                  else begin
                     e = sb_q[k].pop_front();
                     chk("rdy_port", rdy_o[k], NP'(1) << e.port);
                     chk("rdy_latency", cyc, rsp_cyc[k] + 1);
                     if (!e.we) q_model[k][e.port] = e.rdata;
                     chk("q_vector", q_o[k], qpack(k));
                     chk("busy_done", busy_o[k], 1);
                     if (chk_gap[k] && have_prev[k]) chk("rdy_gap", cyc - last_rdy, 4);
                     have_prev[k] = 1;
                     last_rdy = cyc;
                     after_rdy = 1;
                  end
               end
            end
         end
      end

      // Off-chip memory responder.
      initial begin : rsp
         logic [AW-1:0] a;
         bit            w, hg;
         int            d;
         mem_rdy_s[k] = 0;
         mem_q_s[k]   = '0;
         forever begin
            @(negedge clk);
            if (rst_n && (mem_re_o[k] || mem_we_o[k])) begin
               a  = mem_addr_o[k];
               w  = mem_we_o[k];
               hg = hang[k];
               if (w) ext_mem[a] = mem_d_o[k];
               if (spur_issue[k]) begin
                  mem_rdy_s[k] = 1;
                  mem_q_s[k]   = $urandom;
               end
               d = (rsp_delay[k] < 0) ? int'($urandom_range(0, 3)) : rsp_delay[k];
               @(negedge clk);
               mem_rdy_s[k] = 0;
               repeat (d) @(negedge clk);
               if (!hg && rst_n) begin
                  mem_rdy_s[k] = 1;
                  mem_q_s[k]   = w ? DW'($urandom) : rd_ext(a);
                  rsp_cyc[k]   = cyc;
                  @(negedge clk);
                  mem_rdy_s[k] = 0;
               end
            end
         end
      end
   end

   task automatic drive(input int k, input int p, input txn_t t);
      re_s[k][p]              = t.re;
      we_s[k][p]              = t.we;
      addr_s[k][p*AW +: AW]   = t.addr;
      d_s[k][p*DW +: DW]      = t.data;
   endtask

   task automatic undrive(input int k, input int p);
      re_s[k][p] = 1'b0;
      we_s[k][p] = 1'b0;
   endtask

   // Reference: each port with queued work requests continuously; pick winners by the rules.
   task automatic run_batch(input int k);
      txn_t mq [NP][$];
      int   cnt [NP];
      bit   pend [NP];
      bit   anyp;
      int   w, idx, guard, left;
      exp_t e;
      for (int p = 0; p < NP; p++) begin
         mq[p]  = pq[p];
         cnt[p] = 0;
      end
      forever begin
         anyp = 0;
         for (int p = 0; p < NP; p++) begin
            pend[p] = mq[p].size() > 0;
            anyp    = anyp | pend[p];
         end
         if (!anyp) break;
         w = -1;
         if (k == 0) begin
            for (int j = 1; j <= NP; j++) begin
               idx = (rr_ptr_m[k] + j) % NP;
               if (w < 0 && pend[idx]) w = idx;
            end
            rr_ptr_m[k] = w;
         end else begin
            for (int p = 0; p < NP; p++)
               if (w < 0 && pend[p] && cnt[p] >= LIM) w = p;
            for (int p = 0; p < NP; p++)
               if (w < 0 && pend[p]) w = p;
            for (int p = 0; p < NP; p++) begin
               if (!pend[p] || p == w) cnt[p] = 0;
               else if (cnt[p] < 255) cnt[p]++;
            end
         end
         e.port  = w;
         e.we    = mq[w][0].we;
         e.addr  = mq[w][0].addr;
         e.data  = mq[w][0].data;
         e.rdata = '0;
         if (e.we) ref_mem[e.addr] = e.data;
         else      e.rdata = rd_ref(e.addr);
         sb_q[k].push_back(e);
         void'(mq[w].pop_front());
      end

      @(negedge clk);
      for (int p = 0; p < NP; p++)
         if (pq[p].size() > 0) drive(k, p, pq[p][0]);
      guard = 0;
      left  = 1;
      while (left > 0 && guard < 2000) begin
         @(negedge clk);
         guard++;
         for (int p = 0; p < NP; p++) begin
            if (rdy_o[k][p] && pq[p].size() > 0) begin
               void'(pq[p].pop_front());
               if (pq[p].size() > 0) drive(k, p, pq[p][0]);
               else                  undrive(k, p);
            end
         end
         left = 0;
         for (int p = 0; p < NP; p++) left += pq[p].size();
      end
      chk("batch_complete", left, 0);
      if (left > 0) begin
         for (int p = 0; p < NP; p++) begin
            pq[p].delete();
            undrive(k, p);
         end
         sb_q[k].delete();
         repeat (20) @(negedge clk);
      end
   endtask

   task automatic rand_batch(input int k);
      txn_t t;
      int   n;
      for (int p = 0; p < NP; p++) begin
         n = $urandom_range(0, 3);
         for (int j = 0; j < n; j++) begin
            t.we   = 1'($urandom_range(0, 1));
            t.re   = t.we ? 1'($urandom_range(0, 1)) : 1'b1;
            t.addr = AW'($urandom_range(0, 15));
            t.data = $urandom;
            pq[p].push_back(t);
         end
      end
      run_batch(k);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      txn_t t;
      exp_t e;
      int   g;
      int   rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int   fp_exp [9] = '{0, 0, 3, 0, 0, 3, 0, 0, 3};

      for (int k = 0; k < 2; k++) begin
         re_s[k] = '0; we_s[k] = '0; addr_s[k] = '0; d_s[k] = '0;
         rsp_delay[k] = -1; spur_issue[k] = 0; hang[k] = 0;
         chk_gap[k] = 0; have_prev[k] = 0; strobe_seen[k] = 0; rsp_cyc[k] = 0;
         rr_ptr_m[k] = NP - 1;
         for (int p = 0; p < NP; p++) q_model[k][p] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("reset_q", q_o[k], 0);
         chk("reset_ctl", {rdy_o[k], mem_re_o[k], mem_we_o[k], busy_o[k], gid_o[k]}, 0);
         chk("reset_mem_bus", {mem_addr_o[k], mem_d_o[k]}, 0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Round-robin, all ports loaded, immediate memory response.
      rsp_delay[0] = 0; chk_gap[0] = 1; have_prev[0] = 0;
      glog[0].delete();
      for (int p = 0; p < NP; p++)
         for (int j = 0; j < 2; j++) begin
            t.re = 1; t.we = (j == 1); t.addr = AW'(p * 2 + j); t.data = $urandom;
            pq[p].push_back(t);
         end
      run_batch(0);
      chk_gap[0] = 0;
      chk("rr_grant_count", glog[0].size(), 8);
      for (int i = 0; i < 8 && i < glog[0].size(); i++) chk("rr_grant_order", glog[0][i], rr_exp[i]);

      // Single read, memory answers 3 cycles after the strobe.
      ext_mem[16'h100] = 32'hABCD;
      ref_mem[16'h100] = 32'hABCD;
      rsp_delay[0] = 2;
      t.re = 1; t.we = 0; t.addr = 16'h100; t.data = '0;
      pq[1].push_back(t);
      run_batch(0);
      chk("single_read_q1", q_o[0][1*DW +: DW], 32'hABCD);

      // RE and WE together perform a write.
      rsp_delay[0] = -1;
      t.re = 1; t.we = 1; t.addr = 16'h7; t.data = 32'h55;
      pq[2].push_back(t);
      run_batch(0);
      chk("rewe_mem_written", ext_mem[16'h7], 32'h55);

      // Spurious MEM_RDY in IDLE and in ISSUE.
      @(negedge clk);
      mem_q_s[0] = 32'hDEAD_BEEF;
      mem_rdy_s[0] = 1;
      @(negedge clk);
      mem_rdy_s[0] = 0;
      repeat (3) @(negedge clk);
      chk("spurious_idle_q", q_o[0], qpack(0));
      spur_issue[0] = 1; rsp_delay[0] = 1;
      t.re = 1; t.we = 0; t.addr = 16'h3; t.data = '0;
      pq[3].push_back(t);
      run_batch(0);
      spur_issue[0] = 0; rsp_delay[0] = -1;

      for (int b = 0; b < 25; b++) rand_batch(0);

      // Reset during WAIT for a port 0 read.
      @(negedge clk);
      rsp_delay[0] = 0; hang[0] = 1; strobe_seen[0] = 0;
      t.re = 1; t.we = 0; t.addr = 16'h5; t.data = '0;
      e.port = 0; e.we = 0; e.addr = t.addr; e.data = '0; e.rdata = rd_ref(t.addr);
      sb_q[0].push_back(e);
      drive(0, 0, t);
      g = 0;
      while (!strobe_seen[0] && g < 50) begin @(negedge clk); g++; end
      chk("rst_test_issue", strobe_seen[0], 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midwait_reset_q", q_o[0], 0);
      chk("midwait_reset_ctl", {rdy_o[0], mem_re_o[0], mem_we_o[0], busy_o[0], gid_o[0]}, 0);
      chk("midwait_reset_bus", {mem_addr_o[0], mem_d_o[0]}, 0);
      rr_ptr_m[0] = NP - 1;
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < NP; p++) q_model[k][p] = '0;
      hang[0] = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      g = 0;
      while (!rdy_o[0][0] && g < 50) begin @(negedge clk); g++; end
      chk("reissue_after_reset", rdy_o[0][0], 1);
      undrive(0, 0);
      repeat (2) @(negedge clk);
      chk("reissue_q0", q_o[0][0 +: DW], rd_ref(16'h5));
      rsp_delay[0] = -1;

      // Fixed priority with starvation promotion after two losses.
      rsp_delay[1] = 0;
      glog[1].delete();
      for (int j = 0; j < 6; j++) begin
         t.re = 1; t.we = j[0]; t.addr = AW'(8 + j); t.data = $urandom;
         pq[0].push_back(t);
      end
      for (int j = 0; j < 3; j++) begin
         t.re = 1; t.we = 0; t.addr = AW'(j); t.data = '0;
         pq[3].push_back(t);
      end
      run_batch(1);
      chk("fp_grant_count", glog[1].size(), 9);
      for (int i = 0; i < 9 && i < glog[1].size(); i++) chk("fp_grant_order", glog[1][i], fp_exp[i]);

      rsp_delay[1] = -1;
      for (int b = 0; b < 25; b++) rand_batch(1);

      repeat (5) @(negedge clk);
      chk("sb0_drained", sb_q[0].size(), 0);
      chk("sb1_drained", sb_q[1].size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/syrup_offchip_arbiter_n.md
Name: syrup_offchip_arbiter_n

Overview:
- Parametrised N-channel off-chip memory arbiter. It sits between the per-memory-space marshaller/address-mapper outputs and the single off-chip memory port.
- Successor to the fixed-port arbiter: port count, address width and data width are generic.
- Selectable round-robin or fixed-priority arbitration.
- Fixed-priority mode has starvation promotion.
- Exposes grant/busy status for the performance counter.

Parameters:
NUM_PORTS, 4, number of upstream channels (1..8)
W_OFF_A, 32, off-chip address width
W_OFF_D, 512, off-chip data width
MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)
STARVE_LIMIT, 8, in MODE 1: lost arbitrations before a waiting port is promoted; 0 disables promotion (max 255)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-low
ADDR  in  NUM_PORTS*W_OFF_A  per-port address, port i at [i*W_OFF_A +: W_OFF_A]
RE  in  NUM_PORTS  per-port read request, level, held until RDY
WE  in  NUM_PORTS  per-port write request, level, held until RDY
D  in  NUM_PORTS*W_OFF_D  per-port write data
Q  out  NUM_PORTS*W_OFF_D  per-port read data, registered
RDY  out  NUM_PORTS  per-port completion pulse, 1 cycle
MEM_ADDR  out  W_OFF_A  off-chip address
MEM_RE  out  1  off-chip read strobe, 1 cycle
MEM_WE  out  1  off-chip write strobe, 1 cycle
MEM_D  out  W_OFF_D  off-chip write data
MEM_Q  in  W_OFF_D  off-chip read data, valid when MEM_RDY=1
MEM_RDY  in  1  off-chip completion pulse
BUSY  out  1  transaction in flight (state != IDLE)
GRANT_ID  out  3  index of current/last granted port

Behaviour:
- Reset (RST=0, async): state IDLE. All outputs 0 (Q, RDY, MEM_*, BUSY, GRANT_ID). RR pointer = NUM_PORTS-1. Starvation counters = 0.
- Reset mid-transaction aborts it with no RDY. The requester still holds RE/WE, so the request is re-arbitrated after reset.
- A port requests when RE[i]|WE[i]. If both are set, a write is performed and RE is ignored.
- IDLE: if any request is present, select winner g. Register GRANT_ID=g, latch ADDR/D/op, go to ISSUE. No request: stay in IDLE.
- ISSUE: drive MEM_ADDR/MEM_D and assert MEM_RE or MEM_WE for exactly 1 cycle, then go to WAIT. MEM_ADDR/MEM_D stay stable until DONE.
- WAIT: sample MEM_RDY starting the cycle after ISSUE.
  - On MEM_RDY=1 with a read: Q[g] <= MEM_Q.
  - On MEM_RDY=1, go to DONE.
  - No timeout.
- DONE: RDY[g]=1 for one cycle, then IDLE. The requester deasserts its request at that edge.
- Minimum turnaround is 4 cycles (IDLE, ISSUE, WAIT with immediate MEM_RDY, DONE).
- MEM_RDY outside WAIT is ignored.
- Q[i] holds its last read data until port i's next read completes. Writes do not modify Q.
- BUSY=1 in ISSUE, WAIT and DONE.
- Round-robin (MODE 0):
  - Search starts at pointer+1 mod NUM_PORTS; the first requester wins.
  - Pointer <= g on grant, so wrap-around from NUM_PORTS-1 to 0 is seamless.
  - A single requester is granted back-to-back.
- Fixed priority (MODE 1):
  - Lowest requesting index wins, unless promotion applies.
  - Each port has an 8-bit saturating counter. It increments in IDLE grant cycles when the port requests but loses. It clears when the port is granted or is not requesting.
  - Promotion applies when STARVE_LIMIT>0: any requesting port with counter >= STARVE_LIMIT is promoted. The lowest-index promoted port wins over all non-promoted ports.
- NUM_PORTS=1: always grants port 0. Arbitration logic degenerates; behaviour is otherwise identical.
- GRANT_ID bits above clog2(NUM_PORTS) are 0.

Test Plan:
- Single read: port 1 RE, ADDR=0x100; MEM_RDY 3 cycles after MEM_RE with MEM_Q=0xABCD -> MEM_RE 1 cycle at ADDR 0x100; Q[1]=0xABCD with RDY[1] pulse the cycle after MEM_RDY; BUSY falls the next cycle.
- Round-robin fairness: MODE 0, NUM_PORTS=4, all ports request continuously, MEM_RDY immediate -> grant order 0,1,2,3,0,... Each RDY arrives 4 cycles apart.
- Fixed priority with starvation: MODE 1, STARVE_LIMIT=2, ports 0 and 3 request continuously -> grants 0,0,3,0,0,3,... (port 3 is promoted after 2 losses).
- RE+WE simultaneous: port 2 RE=WE=1, D=0x55 -> MEM_WE=1, MEM_RE=0, MEM_D=0x55; Q[2] unchanged; RDY[2] pulse.
- Spurious MEM_RDY: MEM_RDY pulsed in IDLE and in the ISSUE cycle -> no RDY and no Q change; the transaction completes only on a MEM_RDY seen in WAIT.
- Reset mid-WAIT: RST low during WAIT for port 0 read -> all outputs 0 immediately. After release, port 0 (still requesting) is reissued and completes normally.
